// File: rtl/dense_pkg.sv
// Shared types and helpers for the integer dense classifier stages.
package dense_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int PROD_WIDTH = 16;

    typedef enum logic [1:0] {COLLECT, MAC, DONE} state_t;

    // Bits needed to represent 'value' (0 -> 0, 1 -> 1, 9 -> 4, 63 -> 6).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom.sv
module rom
  import dense_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    DEPTH     = 16,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic [clogb2(DEPTH-1)-1:0] addr,
  output logic [WIDTH-1:0]           data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/dense_int_back.sv
// Second dense stage: buffers B activations, LANES-wide MAC over C classes, arg-max out.
// Optional DENSE_INT_BACK_SCORE_EN adds score_o carrying the winning score.
module dense_int_back
    import dense_pkg::*;
#(
    parameter string BIASFILE   = "mini_dense1_bias.txt",
    parameter string KERNELFILE = "mini_dense1_kernel.txt",
    parameter int    B          = 64,
    parameter int    C          = 10,
    parameter int    LANES      = 8,
    parameter int    DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [clogb2(C-1)-1:0]      class_o,
    output logic                        valid_o,
    output logic                        busy_o,
`ifdef DENSE_INT_BACK_SCORE_EN
    output logic signed [ACC_WIDTH-1:0] score_o,
`endif
    output logic                        overrun_o
);

    localparam int K      = B / LANES;
    localparam int CW     = clogb2(C-1);
    localparam int IW     = clogb2(B-1);
    localparam int PW     = clogb2(K+1);
    localparam int KAW    = clogb2(C*K-1);
    localparam int KW     = LANES * DATA_WIDTH;
    localparam int STAGES = 1;

    localparam logic [IW-1:0]  B_LAST = IW'(B-1);
    localparam logic [CW-1:0]  C_LAST = CW'(C-1);
    localparam logic [PW-1:0]  K_P    = PW'(K);
    localparam logic [PW-1:0]  PH_END = PW'(K+1);
    localparam logic [KAW-1:0] K_A    = KAW'(K);

    state_t                        state;
    logic [IW-1:0]                 in_cnt;
    logic [CW-1:0]                 cls;
    logic [PW-1:0]                 ph;
    logic [PW-1:0]                 rd_k;
    logic [STAGES:1]               vld_pipe;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   best;
    logic [CW-1:0]                 best_idx;
    logic [DATA_WIDTH-1:0]         act_buf [B];

    logic                          issue;
    logic [KAW-1:0]                kaddr;
    logic [KW-1:0]                 kword;
    logic [ACC_WIDTH-1:0]          bias_w;
    logic [LANES-1:0][PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]          lane_sum;
    logic signed [ACC_WIDTH-1:0]   score;

    // Phase 0..K-1 issues kernel words; K+1 is the bias/compare slot.
    assign issue = (state == MAC) && (ph < K_P);
    assign kaddr = issue ? (KAW'(cls) * K_A + KAW'(ph)) : '0;

    rom #(.WIDTH(KW), .DEPTH(C*K), .INIT_FILE(KERNELFILE)) u_kern_rom (
        .clk  (clk),
        .addr (kaddr),
        .data (kword)
    );

    rom #(.WIDTH(ACC_WIDTH), .DEPTH(C), .INIT_FILE(BIASFILE)) u_bias_rom (
        .clk  (clk),
        .addr (cls),
        .data (bias_w)
    );

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [DATA_WIDTH-1:0]       a;
            logic [DATA_WIDTH-1:0]       w;
            logic signed [PROD_WIDTH-1:0] a_x;
            logic signed [PROD_WIDTH-1:0] w_x;
            assign a    = act_buf[IW'(int'(rd_k) * LANES + j)];
            assign w    = kword[j*DATA_WIDTH +: DATA_WIDTH];
            // Activation is unsigned, kernel byte is signed.
            assign a_x  = {{(PROD_WIDTH-DATA_WIDTH){1'b0}}, a};
            assign w_x  = {{(PROD_WIDTH-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
            assign prod[j] = a_x * w_x;
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + {{(ACC_WIDTH-PROD_WIDTH){prod[j][PROD_WIDTH-1]}}, prod[j]};
        end
    end

    assign score = acc + bias_w;

    always_ff @(posedge clk) begin
        if (state == COLLECT && valid_i) begin
            act_buf[in_cnt] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= COLLECT;
            in_cnt    <= '0;
            cls       <= '0;
            ph        <= '0;
            rd_k      <= '0;
            vld_pipe  <= '0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            class_o   <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
`ifdef DENSE_INT_BACK_SCORE_EN
            score_o   <= '0;
`endif
        end else begin
            valid_o  <= 1'b0;
            vld_pipe <= issue;
            if (issue) rd_k <= ph;
            if (vld_pipe[STAGES]) acc <= acc + lane_sum;

            unique case (state)
                COLLECT: begin
                    if (valid_i) begin
                        if (in_cnt == B_LAST) begin
                            in_cnt <= '0;
                            state  <= MAC;
                            busy_o <= 1'b1;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (valid_i) overrun_o <= 1'b1;
                    if (ph == PH_END) begin
                        ph  <= '0;
                        acc <= '0;
                        // Strict compare: ties keep the lower class index.
                        if (cls == '0 || score > best) begin
                            best     <= score;
                            best_idx <= cls;
                        end
                        if (cls == C_LAST) begin
                            cls    <= '0;
                            state  <= DONE;
                            busy_o <= 1'b0;
                        end else begin
                            cls <= cls + 1'b1;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                DONE: begin
                    if (valid_i) overrun_o <= 1'b1;
                    valid_o <= 1'b1;
                    class_o <= best_idx;
`ifdef DENSE_INT_BACK_SCORE_EN
                    score_o <= best;
`endif
                    state   <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_int_back.sv
// Directed bench for dense_int_back: ROMs loaded directly, hand-computed class/score/latency.
module tb_dense_int_back;

    localparam int B = 64;
    localparam int C = 10;
    localparam int LANES = 8;
    localparam int K = B / LANES;
    localparam int LAT = C * (K + 2) + 1;

    logic        clk;
    logic        rstn;
    logic        valid_i;
    logic [7:0]  data_i;
    logic [3:0]  class_o;
    logic        valid_o;
    logic        busy_o;
    logic        overrun_o;
`ifdef DENSE_INT_BACK_SCORE_EN
    logic signed [31:0] score_o;
`endif

    int n_chk;
    int n_fail;
    int lat;
    int busy_cyc;

    dense_int_back #(
        .BIASFILE   (""),
        .KERNELFILE (""),
        .B          (B),
        .C          (C),
        .LANES      (LANES),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .class_o   (class_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
`ifdef DENSE_INT_BACK_SCORE_EN
        .score_o   (score_o),
`endif
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // mode 0: row c bytes = c; 1: class 3 = +127, others -128; 2: zero; 3: all -1
    task automatic load_kern(input int mode);
        logic [7:0] b;
        for (int c = 0; c < C; c++) begin
            case (mode)
                0:       b = 8'(c);
                1:       b = (c == 3) ? 8'h7F : 8'h80;
                2:       b = 8'h00;
                default: b = 8'hFF;
            endcase
            for (int k = 0; k < K; k++) dut.u_kern_rom.mem[c*K + k] = {LANES{b}};
        end
    endtask

    // mode 0: all zero; 1: bias[2]=bias[5]=100, others -5
    task automatic load_bias(input int mode);
        for (int c = 0; c < C; c++) begin
            if (mode == 0)                dut.u_bias_rom.mem[c] = 32'sd0;
            else if (c == 2 || c == 5)    dut.u_bias_rom.mem[c] = 32'sd100;
            else                          dut.u_bias_rom.mem[c] = -32'sd5;
        end
    endtask

    // Called and returns at posedge+1; returns right after the B-th valid edge.
    task automatic send_frame(input logic [7:0] v, input int gap);
        for (int i = 0; i < B; i++) begin
            valid_i = 1'b1;
            data_i  = v;
            @(posedge clk);
            #1 valid_i = 1'b0;
            if (i != B - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_result(output int l, output int bc);
        l  = -1;
        bc = busy_o ? 1 : 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (busy_o) bc++;
            if (valid_o) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int exp_cls, input logic [31:0] exp_score);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_class"}, 32'(class_o), 32'(exp_cls));
`ifdef DENSE_INT_BACK_SCORE_EN
        chk({tag, "_score"}, score_o, exp_score);
`else
        if (exp_score == 32'hDEAD_BEEF) n_chk += 0;
`endif
        @(posedge clk);
        #1;
        chk({tag, "_pulse1"}, 32'(valid_o), 32'd0);
        chk({tag, "_hold"}, 32'(class_o), 32'(exp_cls));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;
        load_kern(0);
        load_bias(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_class", 32'(class_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
`ifdef DENSE_INT_BACK_SCORE_EN
        chk("rst_score", score_o, 32'd0);
`endif
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // scores 64*c -> class 9, score 576
        send_frame(8'd1, 1);
        wait_result(lat, busy_cyc);
        chk("t1_busy_cycles", 32'(busy_cyc), 32'(C * (K + 2)));
        check_result("t1", 9, 32'd576);

        // only class 3 positive: 64*127*127
        load_kern(1);
        send_frame(8'd127, 2);
        wait_result(lat, busy_cyc);
        check_result("t2", 3, 32'd1032256);

        // zero kernels, tied biases at 2 and 5; back-to-back input
        load_kern(2);
        load_bias(1);
        send_frame(8'd77, 0);
        wait_result(lat, busy_cyc);
        check_result("t3", 2, 32'd100);

        // all scores -640: class 0 still wins
        load_kern(3);
        load_bias(0);
        send_frame(8'd10, 1);
        wait_result(lat, busy_cyc);
        check_result("t4", 0, 32'hFFFF_FD80);

        // valid_i during MAC and during DONE: dropped, overrun sticky
        load_kern(0);
        send_frame(8'd1, 1);
        fork
            wait_result(lat, busy_cyc);
            begin
                repeat (10) @(posedge clk);
                #1 valid_i = 1'b1;
                data_i = 8'd99;
                @(posedge clk);
                #1 valid_i = 1'b0;
                repeat (89) @(posedge clk);
                #1 valid_i = 1'b1;
                @(posedge clk);
                #1 valid_i = 1'b0;
            end
        join
        chk("t5_lat", 32'(lat), 32'(LAT));
        chk("t5_class", 32'(class_o), 32'd9);
        chk("t5_overrun", 32'(overrun_o), 32'd1);
        // next frame starts on the very cycle after DONE
        send_frame(8'd1, 1);
        wait_result(lat, busy_cyc);
        chk("t5b_overrun_sticky", 32'(overrun_o), 32'd1);
        check_result("t5b", 9, 32'd576);

        // reset in the 50th MAC cycle discards the frame
        send_frame(8'd1, 1);
        repeat (49) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("t6_rst_class", 32'(class_o), 32'd0);
        chk("t6_rst_valid", 32'(valid_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_overrun", 32'(overrun_o), 32'd0);
`ifdef DENSE_INT_BACK_SCORE_EN
        chk("t6_rst_score", score_o, 32'd0);
`endif
        @(posedge clk);
        #1 rstn = 1'b1;
        load_kern(1);
        @(posedge clk);
        #1;
        send_frame(8'd127, 1);
        wait_result(lat, busy_cyc);
        chk("t6_busy_cycles", 32'(busy_cyc), 32'(C * (K + 2)));
        chk("t6_overrun", 32'(overrun_o), 32'd0);
        check_result("t6", 3, 32'd1032256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_int_back.md
# dense_int_back

Second fully-connected stage of the integer classifier. It consumes the serial 8-bit activation stream produced by `dense_int_front`, one value per `valid_i`, and buffers all B values. It then runs a LANES-wide multiply-accumulate over C output classes using ROM kernels and biases, and reports the arg-max class index with a single-cycle `valid_o`.

## Interface
Parameters:
- `BIASFILE`, default "mini_dense1_bias.txt": bias ROM init file; C words of 32 bits, signed.
- `KERNELFILE`, default "mini_dense1_kernel.txt": kernel ROM init file; C*B/LANES words of LANES*DATA_WIDTH bits.
- `B`, default 64: number of input activations per frame (the front stage's B).
- `C`, default 10: number of output classes.
- `LANES`, default 8: multiplies per cycle. Must divide B.
- `DATA_WIDTH`, default 8: activation and kernel width.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: asynchronous active-low reset.
- `valid_i`, input, 1: `data_i` is valid this cycle.
- `data_i`, input, DATA_WIDTH: activation, treated as unsigned 0..127.
- `class_o`, output, clogb2(C-1): winning class index; held until the next result.
- `valid_o`, output, 1: one-cycle pulse when `class_o` updates.
- `busy_o`, output, 1: high while in MAC.
- `overrun_o`, output, 1: sticky; set when `valid_i` arrives while in MAC.

## Operation
- Reset values: `class_o`=0, `valid_o`=0, `busy_o`=0, `overrun_o`=0. Reset also clears the input count, class count, accumulator and best score, and puts the FSM in COLLECT. Reset asserted mid-frame or mid-MAC discards all work; nothing resumes.

State machine:
- COLLECT: each `valid_i` writes `data_i` into buffer slot `in_cnt` and increments `in_cnt`. When `valid_i` arrives with `in_cnt`==B-1, `in_cnt` wraps to 0 and the FSM goes to MAC.
- MAC: for each class c = 0..C-1:
  - Issue kernel addresses c*K+k for k = 0..K-1, where K = B/LANES.
  - Each returned word multiplies LANES buffered activations (slot k*LANES+j against kernel byte j, signed 8x8 giving a 16-bit product) and adds the products into a 32-bit signed accumulator.
  - Then add bias[c] to give score[c].
  - Compare against the best score. When c==C-1, go to DONE.
- DONE: pulse `valid_o`, drive `class_o` = best index, return to COLLECT.

Arithmetic:
- Activations are zero-extended to 9 bits before the signed multiply.
- Accumulation and bias add wrap at 32 bits; there is no saturation.

Arg-max:
- Class 0 always initialises the best score.
- A later class replaces it only if its score is strictly greater, so ties keep the lower index.
- All-negative scores still produce a valid index.

Boundary conditions:
- `valid_i` in MAC or DONE: the data is dropped and `overrun_o` is set until reset.
- `valid_i` in the same cycle as the DONE→COLLECT transition is dropped.
- The first accepted activation of the next frame is the one on the cycle after DONE.

## Timing
- Kernel and bias ROMs have a 1-cycle synchronous read.
- Per class: K address cycles, plus 1 cycle of ROM latency, plus 1 bias/compare cycle, i.e. K+2 cycles.
- Latency from the B-th `valid_i` edge to the `valid_o` pulse is C*(K+2)+1 cycles. For the defaults this is 10*(8+2)+1 = 101.
- `busy_o` is high for exactly C*(K+2) cycles.
- There is no backpressure. The upstream spacing of at least 2 cycles between `valid_i` pulses is tolerated; a back-to-back `valid_i` every cycle is also accepted in COLLECT.

## Configuration
- `DENSE_INT_BACK_SCORE_EN` defined: adds output `score_o` (32 bits, signed). It holds the winning score and updates together with `class_o` on `valid_o`. Its reset value is 0.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `dense_pkg` holds:
  - the `clogb2` function;
  - `ACC_WIDTH`=32 and `PROD_WIDTH`=16;
  - the state type {COLLECT, MAC, DONE}.
- Sub-module: the existing `rom`, instantiated twice, as the bias ROM (32 bits x C) and the kernel ROM (LANES*DATA_WIDTH x C*K).
- The activation buffer is a B x DATA_WIDTH register array inside this block.

## Test plan
- All 64 activations = 1; kernel row c all bytes = c; biases 0 → scores = 64*c, `class_o`=9, `valid_o` exactly 101 cycles after the 64th `valid_i`.
- Activations = 127; class 3 kernel = +127, all others = -128; bias 0 → `class_o`=3, score 64*127*127 = 1032256 (with `DENSE_INT_BACK_SCORE_EN`).
- Kernels 0; bias[2]=bias[5]=100, others -5 → tie resolved to `class_o`=2.
- All kernels -1, activations 10, biases 0 → all scores -640, `class_o`=0, `valid_o` still pulses.
- Drive `valid_i` during `busy_o` → `overrun_o`=1 and stays set; the result equals the no-overrun run.
- Assert `rstn`=0 for 1 cycle at the 50th MAC cycle → all outputs 0. A fresh 64-value frame then yields the correct result with nominal latency.
